// File: rtl/peripheral_burst_splitter.sv
// Splits host Avalon-MM bursts into single-word commands for a clock-crossing
// bridge, bounding outstanding reads and returning read data one cycle later.
module peripheral_burst_splitter #(
  parameter int MAX_PENDING = 8
) (
  input  logic        slave_clk,
  input  logic        slave_reset_n,
  input  logic [7:0]  s_address,
  input  logic [4:0]  s_burstcount,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  input  logic [3:0]  s_byteenable,
  output logic        s_waitrequest,
  output logic [31:0] s_readdata,
  output logic        s_readdatavalid,
  output logic [7:0]  m_address,
  output logic [3:0]  m_byteenable,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic        err_unexpected_rdv
);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_cnt_q, addr_cnt_d;
  logic [4:0]  beats_left_q, beats_left_d;
  logic [4:0]  pending_q, pending_d;
  logic        s_readdatavalid_q, s_readdatavalid_d;
  logic [31:0] s_readdata_q, s_readdata_d;
  logic        err_q, err_d;

  logic [4:0]  eff_count;
  logic        can_issue;
  logic        rd_accept;

  assign eff_count = (s_burstcount == 5'd0) ? 5'd1 : s_burstcount;
  assign can_issue = pending_q < 5'(MAX_PENDING);

  // Command path: everything the bridge sees is decoded from the current state.
  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no
    // branch below can leave a signal unassigned and infer a latch.
    state_d       = state_q;
    addr_cnt_d    = addr_cnt_q;
    beats_left_d  = beats_left_q;
    s_waitrequest = 1'b0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_address     = 8'h00;
    m_writedata   = 32'h0;
    m_byteenable  = 4'h0;
    rd_accept     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s_read) begin
          addr_cnt_d   = s_address;
          beats_left_d = eff_count;
          state_d      = RD_BURST;
        end else if (s_write) begin
          if (pending_q != 5'd0) begin
            // Writes must not overtake reads still in flight through the bridge.
            s_waitrequest = 1'b1;
          end else begin
            m_write       = 1'b1;
            m_address     = s_address;
            m_writedata   = s_writedata;
            m_byteenable  = s_byteenable;
            s_waitrequest = m_waitrequest;
            if (!m_waitrequest) begin
              addr_cnt_d   = s_address + 8'd1;
              beats_left_d = eff_count - 5'd1;
              if (eff_count != 5'd1) state_d = WR_BURST;
            end
          end
        end
      end

      RD_BURST: begin
        s_waitrequest = 1'b1;
        if (can_issue) begin
          m_read       = 1'b1;
          m_address    = addr_cnt_q;
          m_byteenable = 4'hF;
          if (!m_waitrequest) begin
            rd_accept    = 1'b1;
            addr_cnt_d   = addr_cnt_q + 8'd1;
            beats_left_d = beats_left_q - 5'd1;
            if (beats_left_q <= 5'd1) state_d = IDLE;
          end
        end
      end

      WR_BURST: begin
        s_waitrequest = m_waitrequest;
        m_write       = s_write;
        m_address     = addr_cnt_q;
        if (s_write) begin
          m_writedata  = s_writedata;
          m_byteenable = s_byteenable;
          if (!m_waitrequest) begin
            addr_cnt_d   = addr_cnt_q + 8'd1;
            beats_left_d = beats_left_q - 5'd1;
            if (beats_left_q <= 5'd1) state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outstanding-read accounting and the registered read-return path.
  always_comb begin
    pending_d         = pending_q;
    err_d             = err_q;
    s_readdatavalid_d = m_readdatavalid;
    s_readdata_d      = m_readdatavalid ? m_readdata : s_readdata_q;

    if (m_readdatavalid && pending_q == 5'd0) begin
      // Spurious return: flag it and keep the counter from underflowing.
      err_d     = 1'b1;
      pending_d = rd_accept ? 5'd1 : 5'd0;
    end else if (rd_accept && !m_readdatavalid) begin
      pending_d = pending_q + 5'd1;
    end else if (!rd_accept && m_readdatavalid) begin
      pending_d = pending_q - 5'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed before this edge regardless of block order.
  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      state_q           <= IDLE;
      addr_cnt_q        <= 8'h00;
      beats_left_q      <= 5'd0;
      pending_q         <= 5'd0;
      s_readdatavalid_q <= 1'b0;
      s_readdata_q      <= 32'h0;
      err_q             <= 1'b0;
    end else begin
      state_q           <= state_d;
      addr_cnt_q        <= addr_cnt_d;
      beats_left_q      <= beats_left_d;
      pending_q         <= pending_d;
      s_readdatavalid_q <= s_readdatavalid_d;
      s_readdata_q      <= s_readdata_d;
      err_q             <= err_d;
    end
  end

  assign s_readdatavalid    = s_readdatavalid_q;
  assign s_readdata         = s_readdata_q;
  assign err_unexpected_rdv = err_q;

endmodule

// File: tb/tb_peripheral_burst_splitter.sv
// Directed self-checking bench for peripheral_burst_splitter: read/write bursts,
// outstanding-read limit, write ordering, spurious returns and async reset.
module tb_peripheral_burst_splitter;

  logic        slave_clk = 1'b0;
  logic        slave_reset_n;
  logic [7:0]  s_address;
  logic [4:0]  s_burstcount;
  logic        s_read, s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;
  logic [7:0]  m_address;
  logic [3:0]  m_byteenable;
  logic        m_read, m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic        err_unexpected_rdv;

  int checks   = 0;
  int failures = 0;

  peripheral_burst_splitter #(.MAX_PENDING(8)) dut (
    .slave_clk          (slave_clk),
    .slave_reset_n      (slave_reset_n),
    .s_address          (s_address),
    .s_burstcount       (s_burstcount),
    .s_read             (s_read),
    .s_write            (s_write),
    .s_writedata        (s_writedata),
    .s_byteenable       (s_byteenable),
    .s_waitrequest      (s_waitrequest),
    .s_readdata         (s_readdata),
    .s_readdatavalid    (s_readdatavalid),
    .m_address          (m_address),
    .m_byteenable       (m_byteenable),
    .m_read             (m_read),
    .m_write            (m_write),
    .m_writedata        (m_writedata),
    .m_waitrequest      (m_waitrequest),
    .m_readdata         (m_readdata),
    .m_readdatavalid    (m_readdatavalid),
    .err_unexpected_rdv (err_unexpected_rdv)
  );

  always #5 slave_clk = ~slave_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks follow after a further 1 ns.
  task automatic tick();
    @(posedge slave_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic host(input logic rd, input logic wr, input logic [7:0] addr,
                      input logic [4:0] bc, input logic [31:0] wd, input logic [3:0] be);
    s_read = rd; s_write = wr; s_address = addr;
    s_burstcount = bc; s_writedata = wd; s_byteenable = be;
  endtask

  task automatic bridge(input logic mw, input logic rdv, input logic [31:0] rdata);
    m_waitrequest = mw; m_readdatavalid = rdv; m_readdata = rdata;
  endtask

  task automatic check_rd_cmd(input string tag, input logic [7:0] addr);
    check({tag, "_m_read"}, 32'(m_read), 32'd1);
    check({tag, "_m_addr"}, 32'(m_address), 32'(addr));
  endtask

  initial begin
    slave_reset_n = 1'b0;
    host(0, 0, 8'h00, 5'd0, 32'h0, 4'h0);
    bridge(0, 0, 32'h0);
    #12;
    check("rst_srdv", 32'(s_readdatavalid), 32'd0);
    check("rst_srdata", s_readdata, 32'h0);
    check("rst_err", 32'(err_unexpected_rdv), 32'd0);
    check("rst_m_read", 32'(m_read), 32'd0);
    check("rst_m_write", 32'(m_write), 32'd0);
    slave_reset_n = 1'b1;
    tick();

    // Read burst 0x10 x4, bridge returns each word two cycles after its command.
    host(1, 0, 8'h10, 5'd4, 32'h0, 4'h0); settle();
    check("rdA_accept_swait", 32'(s_waitrequest), 32'd0);
    check("rdA_accept_no_mread", 32'(m_read), 32'd0);
    tick(); host(0, 0, 8'h00, 5'd0, 32'h0, 4'h0); settle();
    check_rd_cmd("rdA_b0", 8'h10);
    check("rdA_swait_busy", 32'(s_waitrequest), 32'd1);
    check("rdA_be", 32'(m_byteenable), 32'hF);
    tick(); settle();
    check_rd_cmd("rdA_b1", 8'h11);
    tick(); bridge(0, 1, 32'hA0); settle();
    check_rd_cmd("rdA_b2", 8'h12);
    tick(); bridge(0, 1, 32'hA1); settle();
    check_rd_cmd("rdA_b3", 8'h13);
    check("rdA_ret0_v", 32'(s_readdatavalid), 32'd1);
    check("rdA_ret0_d", s_readdata, 32'hA0);
    tick(); bridge(0, 1, 32'hA2); settle();
    check("rdA_done_mread", 32'(m_read), 32'd0);
    check("rdA_ret1_d", s_readdata, 32'hA1);
    tick(); bridge(0, 1, 32'hA3); settle();
    check("rdA_ret2_d", s_readdata, 32'hA2);
    tick(); bridge(0, 0, 32'hDEAD); settle();
    check("rdA_ret3_v", 32'(s_readdatavalid), 32'd1);
    check("rdA_ret3_d", s_readdata, 32'hA3);
    tick(); settle();
    check("rdA_idle_v", 32'(s_readdatavalid), 32'd0);
    check("rdA_hold_d", s_readdata, 32'hA3);

    // Spurious return with nothing pending.
    bridge(0, 1, 32'h5A); settle();
    check("spur_err_before", 32'(err_unexpected_rdv), 32'd0);
    tick(); bridge(0, 0, 32'h0); settle();
    check("spur_err", 32'(err_unexpected_rdv), 32'd1);
    check("spur_srdv", 32'(s_readdatavalid), 32'd1);
    check("spur_srdata", s_readdata, 32'h5A);

    // Write burst at 0xFE x3 with the second beat stalled for three cycles.
    host(0, 1, 8'hFE, 5'd3, 32'hD0, 4'h3); settle();
    check("wr_b0_mwrite", 32'(m_write), 32'd1);
    check("wr_b0_addr", 32'(m_address), 32'hFE);
    check("wr_b0_data", m_writedata, 32'hD0);
    check("wr_b0_be", 32'(m_byteenable), 32'h3);
    check("wr_b0_swait", 32'(s_waitrequest), 32'd0);
    tick(); host(0, 1, 8'h00, 5'd0, 32'hD1, 4'hC); bridge(1, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("wr_b1_stall_addr", 32'(m_address), 32'hFF);
      check("wr_b1_stall_data", m_writedata, 32'hD1);
      check("wr_b1_stall_mwrite", 32'(m_write), 32'd1);
      check("wr_b1_stall_swait", 32'(s_waitrequest), 32'd1);
      tick();
    end
    bridge(0, 0, 32'h0); settle();
    check("wr_b1_addr", 32'(m_address), 32'hFF);
    check("wr_b1_swait", 32'(s_waitrequest), 32'd0);
    tick(); host(0, 1, 8'h00, 5'd0, 32'hD2, 4'hF); settle();
    check("wr_b2_addr_wrap", 32'(m_address), 32'h00);
    check("wr_b2_data", m_writedata, 32'hD2);
    tick(); host(0, 0, 8'h00, 5'd0, 32'hFFFF, 4'hF); settle();
    check("wr_idle_mwrite", 32'(m_write), 32'd0);
    check("wr_idle_data", m_writedata, 32'h0);
    check("wr_idle_be", 32'(m_byteenable), 32'h0);

    // Write behind two outstanding reads waits until both return.
    host(1, 0, 8'h20, 5'd2, 32'h0, 4'h0);
    tick(); host(0, 0, 8'h00, 5'd0, 32'h0, 4'h0); settle();
    check_rd_cmd("ord_r0", 8'h20);
    tick(); settle();
    check_rd_cmd("ord_r1", 8'h21);
    tick(); host(0, 1, 8'h30, 5'd1, 32'hE0, 4'hF); settle();
    check("ord_wait2_swait", 32'(s_waitrequest), 32'd1);
    check("ord_wait2_mwrite", 32'(m_write), 32'd0);
    check("ord_wait2_mread", 32'(m_read), 32'd0);
    tick(); bridge(0, 1, 32'hB0); settle();
    check("ord_wait1a_swait", 32'(s_waitrequest), 32'd1);
    tick(); bridge(0, 1, 32'hB1); settle();
    check("ord_wait1b_swait", 32'(s_waitrequest), 32'd1);
    check("ord_wait1b_mwrite", 32'(m_write), 32'd0);
    tick(); bridge(0, 0, 32'h0); settle();
    check("ord_go_mwrite", 32'(m_write), 32'd1);
    check("ord_go_addr", 32'(m_address), 32'h30);
    check("ord_go_data", m_writedata, 32'hE0);
    check("ord_go_swait", 32'(s_waitrequest), 32'd0);
    tick(); host(0, 0, 8'h00, 5'd0, 32'h0, 4'h0); settle();
    check("ord_single_done", 32'(m_write), 32'd0);

    // 16-beat read with MAX_PENDING=8 and the bridge silent.
    host(1, 0, 8'h40, 5'd16, 32'h0, 4'h0);
    tick(); host(0, 0, 8'h00, 5'd0, 32'h0, 4'h0); settle();
    for (int i = 0; i < 8; i++) begin
      check_rd_cmd("lim_beat", 8'(8'h40 + i));
      tick(); settle();
    end
    for (int i = 0; i < 12; i++) begin
      check("lim_stall_mread", 32'(m_read), 32'd0);
      tick(); settle();
    end
    bridge(0, 1, 32'hC0); settle();
    check("lim_ret_mread", 32'(m_read), 32'd0);
    tick(); bridge(0, 0, 32'h0); settle();
    check_rd_cmd("lim_extra", 8'h48);
    tick(); settle();
    check("lim_restall_mread", 32'(m_read), 32'd0);

    // Asynchronous reset mid-burst, then a stale return flags an error.
    #2; slave_reset_n = 1'b0; #1;
    check("arst_mread", 32'(m_read), 32'd0);
    check("arst_err", 32'(err_unexpected_rdv), 32'd0);
    check("arst_srdv", 32'(s_readdatavalid), 32'd0);
    check("arst_srdata", s_readdata, 32'h0);
    #1; slave_reset_n = 1'b1;
    tick(); bridge(0, 1, 32'h77);
    tick(); bridge(0, 0, 32'h0); settle();
    check("stale_err", 32'(err_unexpected_rdv), 32'd1);
    check("stale_srdata", s_readdata, 32'h77);

    // Reset on beat 2 of a 4-beat read; next burst taken on the first edge after release.
    host(1, 0, 8'h80, 5'd4, 32'h0, 4'h0);
    tick(); host(0, 0, 8'h00, 5'd0, 32'h0, 4'h0); settle();
    check_rd_cmd("mid_b0", 8'h80);
    tick(); settle();
    check_rd_cmd("mid_b1", 8'h81);
    slave_reset_n = 1'b0; #1;
    check("mid_rst_mread", 32'(m_read), 32'd0);
    check("mid_rst_err", 32'(err_unexpected_rdv), 32'd0);
    check("mid_rst_swait", 32'(s_waitrequest), 32'd0);
    #1; slave_reset_n = 1'b1;
    host(1, 0, 8'h90, 5'd1, 32'h0, 4'h0); settle();
    check("post_rst_swait", 32'(s_waitrequest), 32'd0);
    tick(); host(0, 0, 8'h00, 5'd0, 32'h0, 4'h0); settle();
    check_rd_cmd("post_rst_b0", 8'h90);
    tick(); settle();
    check("post_rst_done", 32'(m_read), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
